fifo_thr: RTL



---
 rtl/fifo_thr_pkg.sv | 17 +
 rtl/fifo_thr_ram.sv | 25 ++
 rtl/fifo_thr.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fifo_thr_pkg.sv
// Shared helpers for the fifo_thr stream buffer: occupancy threshold compares and error-flag layout.
// The error flags exist only when FIFO_THR_ERR_FLAGS_EN is defined.
package fifo_thr_pkg;

    localparam int ERR_W       = 2;
    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UNF_BIT = 1;

    function automatic logic cnt_ge(input logic [31:0] cnt, input logic [31:0] thr);
        return (cnt >= thr);
    endfunction

    function automatic logic cnt_le(input logic [31:0] cnt, input logic [31:0] thr);
        return (cnt <= thr);
    endfunction

endpackage

// File: rtl/fifo_thr_ram.sv
// Simple dual-port storage for fifo_thr: synchronous write, asynchronous read, no reset.
module fifo_thr_ram #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_r [2**AWIDTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/fifo_thr.sv
// Single-clock FIFO with true occupancy count, programmable thresholds and normal/showahead reads.
// Define FIFO_THR_ERR_FLAGS_EN to add sticky ovf_o/unf_o flags for ignored requests.
module fifo_thr
    import fifo_thr_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int AWIDTH       = 4,
    parameter int SHOWAHEAD    = 0,
    parameter int ALMOST_FULL  = 2**AWIDTH - 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wr_req_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rd_req_i,
    output logic [DWIDTH-1:0] q_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              almost_empty_o
`ifdef FIFO_THR_ERR_FLAGS_EN
    ,
    output logic              ovf_o,
    output logic              unf_o
`endif
);

    typedef logic [AWIDTH:0] fifo_cnt_t;

    localparam fifo_cnt_t         CNT_ZERO_C = {(AWIDTH+1){1'b0}};
    localparam fifo_cnt_t         CNT_ONE_C  = {{AWIDTH{1'b0}}, 1'b1};
    localparam fifo_cnt_t         CNT_FULL_C = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH-1:0] PTR_ZERO_C = {AWIDTH{1'b0}};
    localparam logic [AWIDTH-1:0] PTR_ONE_C  = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic [AWIDTH-1:0] wr_ptr_r;
    logic [AWIDTH-1:0] rd_ptr_r;
    fifo_cnt_t         cnt_r;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic [DWIDTH-1:0] ram_rdata_s;

    assign usedw_o        = cnt_r;
    assign empty_o        = (cnt_r == CNT_ZERO_C);
    assign full_o         = (cnt_r == CNT_FULL_C);
    assign almost_full_o  = cnt_ge(32'(cnt_r), 32'(ALMOST_FULL));
    assign almost_empty_o = cnt_le(32'(cnt_r), 32'(ALMOST_EMPTY));

    // Request qualification: a full FIFO still accepts a write when a read frees a slot
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        if (srst_i) begin
            rd_acc_s = rd_req_i & ~empty_o;
            wr_acc_s = wr_req_i & (~full_o | rd_acc_s);
        end else begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
        end
    end

    // Pointer and occupancy count update
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            wr_ptr_r <= PTR_ZERO_C;
            rd_ptr_r <= PTR_ZERO_C;
            cnt_r    <= CNT_ZERO_C;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE_C;
                2'b01:   cnt_r <= cnt_r - CNT_ONE_C;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    fifo_thr_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_r),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_r),
        .rdata_o (ram_rdata_s)
    );

    if (SHOWAHEAD != 0) begin : g_showahead
        assign q_o = ram_rdata_s;
    end else begin : g_normal
        logic [DWIDTH-1:0] q_r;

        // Read data register: loads the head word on an accepted read, holds otherwise
        always_ff @(posedge clk_i) begin
            if (!srst_i) begin
                q_r <= {DWIDTH{1'b0}};
            end else if (rd_acc_s) begin
                q_r <= ram_rdata_s;
            end
        end

        assign q_o = q_r;
    end

`ifdef FIFO_THR_ERR_FLAGS_EN
    logic [ERR_W-1:0] err_r;

    // Sticky overflow/underflow capture, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            err_r <= {ERR_W{1'b0}};
        end else begin
            err_r[ERR_OVF_BIT] <= err_r[ERR_OVF_BIT] | (wr_req_i & ~wr_acc_s);
            err_r[ERR_UNF_BIT] <= err_r[ERR_UNF_BIT] | (rd_req_i & ~rd_acc_s);
        end
    end

    assign ovf_o = err_r[ERR_OVF_BIT];
    assign unf_o = err_r[ERR_UNF_BIT];
`endif

endmodule
